data_memory_bytelane: RTL and testbench
=======================================

// Module: data_memory_bytelane
// PURPOSE
//  Parametrised byte-addressed data memory for the 32-bit pipeline MEM stage.
//  Supports byte/half/word loads and stores with byte-lane enables and signed or unsigned load extension.
//  Uses a valid/ready request port and a 1-cycle registered response.
//  Reset clears the array one word per cycle; requests are refused until clearing completes.
//  Misaligned and out-of-range accesses are flagged instead of silently aliasing.
// PARAMETERS
//  ADDR_W       32    request address width (bits)
//  DEPTH_BYTES  1024  memory size in bytes; power of two, multiple of 4, >= 8
//  BIG_ENDIAN   1     1: byte at addr[1:0]=0 is word bits [31:24]; 0: bits [7:0]
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       memory can accept a request this cycle
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 byte, 01 half, 10 word, 11 reserved
//  req_signed in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid  out  1       response strobe, exactly one per accepted request
//  rsp_rdata  out  32      load data, right-justified and extended; 0 for stores and errors
//  rsp_err    out  1       accepted request was misaligned, out of range, or reserved size
//  init_done  out  1       array clear finished
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; state=INIT, clr_ptr=0.
//  FSM states:
//   INIT: each cycle writes 0 to word clr_ptr and increments clr_ptr.
//         After writing word DEPTH_BYTES/4-1 -> IDLE, and init_done=1 from the next cycle.
//         Clearing takes DEPTH_BYTES/4 cycles.
//   IDLE: req_ready=1. It is combinational from state only, never from req_valid.
//  Accept = req_valid & req_ready. Inputs are sampled on the accept edge.
//  Error on an accepted request: size==11, half with addr[0]=1, word with addr[1:0]!=0,
//   or addr >= DEPTH_BYTES. Address bits above the array size are NOT masked.
//  Store, no error: written at the accept edge, only the addressed lanes.
//   Lanes follow BIG_ENDIAN; other bytes are unchanged.
//  Load, no error: the array is read at the accept edge and the lane is extracted.
//   A byte or half is extended per req_signed. A word ignores req_signed.
//  Response: rsp_valid=1 for exactly the cycle after accept, with rsp_rdata/rsp_err.
//   The consumer cannot stall; there is no response backpressure.
//  Error: the store is suppressed, rsp_rdata=0, rsp_err=1. The array is untouched.
//  Throughput: 1 request/cycle in IDLE. Back-to-back accepts are allowed.
//  Read-after-write: a load accepted in the cycle after a store to the same bytes returns the new data.
//  No same-cycle bypass is needed, since one request is accepted per cycle.
//  rst asserted at any time, including mid-INIT or with a response pending:
//   the next cycle shows reset values and clearing restarts at word 0.
//   A pending response is dropped.
//  rsp_rdata and rsp_err hold 0 whenever rsp_valid=0.
// STRUCTURE
//  Package dmem_pkg holds:
//   - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
//   - state enum {INIT, IDLE}
//   - function lane_mask(size, addr[1:0], big_endian) -> 4-bit byte enable
//  Sub-module dmem_lane_align (combinational) holds two paths:
//   - store path: replicate wdata onto lanes
//   - load path: select the lane from the 32-bit word, then extend
//  The array is reg [31:0] mem[DEPTH_BYTES/4] with per-lane write enables, indexed by addr[log2(DEPTH)-1:2].
// TESTING
//  1. Reset, DEPTH_BYTES=1024 -> req_ready=0 for 256 cycles, then 1.
//     init_done=1; a word load at 0x3FC returns 0.
//  2. Word store 0x11223344 @0x10, then byte loads @0x10..0x13 (BIG_ENDIAN=1) -> 0x11,0x22,0x33,0x44.
//     Each response arrives 1 cycle after its accept.
//  3. Byte store 0x80 @0x21, then signed byte load @0x21 -> 0xFFFFFF80, unsigned -> 0x00000080.
//     A word load @0x20 shows only lane 1 changed.
//  4. Half store @0x31, word load @0x42, word store @0x400 -> rsp_err=1 and rsp_rdata=0 for each.
//     A subsequent word load @0x30 and @0x00 shows the memory unchanged.
//  5. Back-to-back word store 0xDEADBEEF @0x8, then word load @0x8 on the next cycle -> 0xDEADBEEF.
//     rsp_valid is high on 2 consecutive cycles.
//  6. Assert rst mid-INIT (cycle 100) and again with a load response pending -> rsp_valid=0 next cycle.
//     Clearing restarts and takes a full 256 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helper for the byte-lane data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {INIT, IDLE} state_t;

  // Bit i of the mask enables word bits [8i+7:8i]; misaligned halves are rejected upstream.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       big_endian);
    logic [1:0] lane;
    lane_mask = 4'b0000;
    lane = big_endian ? (2'd3 - addr_lo) : addr_lo;
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = (addr_lo[1] ^ big_endian) ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// Request/response bus between the MEM stage and the byte-lane data memory.
interface data_memory_bytelane_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data onto lanes and extracts/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    wlanes = wdata;
    case (size)
      SZ_BYTE: wlanes = {4{wdata[7:0]}};
      SZ_HALF: wlanes = {2{wdata[15:0]}};
      default: wlanes = wdata;
    endcase
  end

  // lane names the least-significant byte of the datum inside the word
  always_comb begin
    lane = 2'd0;
    case (size)
      SZ_BYTE: lane = BIG_ENDIAN ? (2'd3 - addr_lo) : addr_lo;
      SZ_HALF: lane = BIG_ENDIAN ? {~addr_lo[1], 1'b0} : {addr_lo[1], 1'b0};
      default: lane = 2'd0;
    endcase
  end

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    rdata = shifted;
    case (size)
      SZ_BYTE: rdata = {{24{load_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{load_signed & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory with lane enables, 1-cycle registered response and clear-on-reset.
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  data_memory_bytelane_if.slave bus
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);
  localparam int AB_W  = $clog2(DEPTH_BYTES);

  state_t            state, state_next;
  logic [IDX_W-1:0]  clr_ptr;
  logic              clr_we;
  logic              ready;
  logic              accept;
  logic              err;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        mask;
  logic [31:0]       wlanes;
  logic [31:0]       ld_data;
  logic [31:0]       mem [WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    clr_we     = 1'b0;
    case (state)
      INIT: begin
        clr_we = 1'b1;
        if (clr_ptr == IDX_W'(WORDS - 1)) state_next = IDLE;
      end
      IDLE: ready = 1'b1;
      default: state_next = INIT;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.init_done = (state == IDLE);

  assign addr   = bus.req_addr;
  assign idx    = addr[AB_W-1:2];
  assign accept = bus.req_valid & ready & ~rst;
  assign mask   = lane_mask(bus.req_size, addr[1:0], BIG_ENDIAN);

  // Upper address bits are compared, not masked, so out-of-range never aliases
  assign err = (bus.req_size == SZ_RSVD)
             | ((bus.req_size == SZ_HALF) & addr[0])
             | ((bus.req_size == SZ_WORD) & (addr[1:0] != 2'b00))
             | (64'(addr) >= 64'(DEPTH_BYTES));

  dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size        (bus.req_size),
    .addr_lo     (addr[1:0]),
    .load_signed (bus.req_signed),
    .wdata       (bus.req_wdata),
    .rword       (mem[idx]),
    .wlanes      (wlanes),
    .rdata       (ld_data)
  );

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (accept && bus.req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_err   <= accept & err;
      bus.rsp_rdata <= (accept && !bus.req_we && !err) ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: byte-array reference model checked every cycle plus directed literal checks.
module tb_data_memory_bytelane;

  localparam int DEPTH = 1024;
  localparam bit BE    = 1'b1;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   checking = 1'b0;

  always #5 clk = ~clk;

  data_memory_bytelane_if #(.ADDR_W(32)) bus ();

  data_memory_bytelane #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(BE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mdl_mem [DEPTH];
  int          init_cnt;
  bit          mdl_ready;
  logic        exp_valid, exp_err;
  logic [31:0] exp_rdata;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, datum bytes laid out by endianness
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
      init_cnt  = 0;
      mdl_ready = 1'b0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
      if (mdl_ready && bus.req_valid === 1'b1) begin
        int          n, a, pos;
        logic [31:0] val;
        exp_valid = 1'b1;
        n = (bus.req_size == 2'b00) ? 1 : (bus.req_size == 2'b01) ? 2 : 4;
        exp_err = (bus.req_size == 2'b11) || (bus.req_addr % n != 0) || (bus.req_addr >= DEPTH);
        if (!exp_err) begin
          a = int'(bus.req_addr);
          if (bus.req_we) begin
            for (int i = 0; i < n; i++) begin
              pos = BE ? (n - 1 - i) : i;
              mdl_mem[a + i] = 8'(bus.req_wdata >> (8 * pos));
            end
          end else begin
            val = '0;
            for (int i = 0; i < n; i++) begin
              pos = BE ? i : (n - 1 - i);
              val = (val << 8) | 32'(mdl_mem[a + pos]);
            end
            if (bus.req_signed && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 1);
            exp_rdata = val;
          end
        end
      end
      if (!mdl_ready) begin
        init_cnt++;
        if (init_cnt == DEPTH / 4) mdl_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check_output("cyc_req_ready", 32'(bus.req_ready), 32'(mdl_ready));
      check_output("cyc_init_done", 32'(bus.init_done), 32'(mdl_ready));
      check_output("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      check_output("cyc_rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      check_output("cyc_rsp_rdata", bus.rsp_rdata, exp_rdata);
    end
  end

  task automatic wait_init(input string name);
    int cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check_output({name, "_cycles"}, 32'(cnt), 32'd256);
    check_output({name, "_done"}, 32'(bus.init_done), 32'd1);
  endtask

  // Presents one request at a falling edge; returns the response seen one cycle after accept
  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_output("rsp_latency", 32'(bus.rsp_valid), 32'd1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_bytes [4];

  initial begin
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    rst = 1'b0;

    wait_init("init");
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, er);
    check_output("load_3fc", rd, 32'h0);

    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, er);
    check_output("store_w_err", 32'(er), 32'd0);
    exp_bytes = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 2'b00, 1'b0, 32'h10 + 32'(i), 32'h0, rd, er);
      check_output("byte_lane", rd, exp_bytes[i]);
    end

    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'hAAAAAA80, rd, er);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er);
    check_output("byte_signed", rd, 32'hFFFFFF80);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, er);
    check_output("byte_unsigned", rd, 32'h00000080);
    apply_stimulus(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, rd, er);
    check_output("word_lane1", rd, 32'h00800000);

    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h52, 32'h12348001, rd, er);
    apply_stimulus(1'b0, 2'b01, 1'b1, 32'h52, 32'h0, rd, er);
    check_output("half_signed", rd, 32'hFFFF8001);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd, er);
    check_output("half_word", rd, 32'h00008001);

    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFF, rd, er);
    check_output("half_mis_err", 32'(er), 32'd1);
    check_output("half_mis_data", rd, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, rd, er);
    check_output("word_mis_err", 32'(er), 32'd1);
    check_output("word_mis_data", rd, 32'h0);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, rd, er);
    check_output("oor_store_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, rd, er);
    check_output("oor_load_err", 32'(er), 32'd1);
    check_output("oor_load_data", rd, 32'h0);
    apply_stimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er);
    check_output("rsvd_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
    check_output("after_err_30", rd, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd, er);
    check_output("after_err_00", rd, 32'h0);

    bus.req_valid = 1'b1;
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h8; bus.req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.req_we = 1'b0;
    check_output("b2b_first_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_output("b2b_second_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("b2b_raw_data", bus.rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check_output("b2b_idle_valid", 32'(bus.rsp_valid), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_output("mid_init_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init("reinit");

    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'h00000055, rd, er);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h4;
    @(negedge clk);
    check_output("pend_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("pend_data", bus.rsp_rdata, 32'h55);
    rst = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_output("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    wait_init("postrst");
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er);
    check_output("cleared_04", rd, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er);
    check_output("cleared_08", rd, 32'h0);

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
